// File: rtl/audio_fx_pkg.sv
// Shared constants and the frame-sequencing state type for the stereo gain stage.
package audio_fx_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 14;

    localparam logic [SAMPLE_W-1:0] SMP_MAX    = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] SMP_MIN    = 24'h800000;
    localparam logic [GAIN_W-1:0]   GAIN_UNITY = 16'h4000;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MULT    = 2'd1,
        SAT     = 2'd2,
        OUT     = 2'd3
    } state_e;

endpackage

// File: rtl/audio_gain_sat.sv
// One channel: registered sample*gain product, then round-half-up and clamp to
// the signed sample range, flagging when the clamp engaged.
module audio_gain_sat
    import audio_fx_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [GAIN_W-1:0]   gain_i,
    output logic [SAMPLE_W-1:0] result_o,
    output logic                clip_o
);

    localparam int PW = SAMPLE_W + GAIN_W + 1;
    localparam logic signed [PW-1:0] HALF    = PW'(1 << (GAIN_FRAC - 1));
    localparam logic signed [PW-1:0] MAX_EXT = PW'($signed(SMP_MAX));
    localparam logic signed [PW-1:0] MIN_EXT = PW'($signed(SMP_MIN));

    logic signed [PW-1:0] p_q, p_d;
    logic signed [PW-1:0] rnd;

    // Gain is unsigned, so it is zero-extended by one bit before the signed multiply.
    always_comb begin
        p_d = p_q;
        if (load_i) begin
            p_d = PW'($signed(sample_i)) * PW'($signed({1'b0, gain_i}));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    always_comb begin
        rnd      = (p_q + HALF) >>> GAIN_FRAC;
        result_o = rnd[SAMPLE_W-1:0];
        clip_o   = 1'b0;
        if (rnd > MAX_EXT) begin
            result_o = SMP_MAX;
            clip_o   = 1'b1;
        end else if (rnd < MIN_EXT) begin
            result_o = SMP_MIN;
            clip_o   = 1'b1;
        end
    end

endmodule

// File: rtl/audio_stereo_gain.sv
// Stereo gain/mute stage: gathers an L/R pair from independent ADC streams,
// scales both by a common gain, and holds the frame until both DAC sides accept it.
module audio_stereo_gain
    import audio_fx_pkg::*;
#(
    parameter int CLIP_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] adc_l_data,
    input  logic                adc_l_valid,
    output logic                adc_l_ready,
    input  logic [SAMPLE_W-1:0] adc_r_data,
    input  logic                adc_r_valid,
    output logic                adc_r_ready,
    output logic [SAMPLE_W-1:0] dac_l_data,
    output logic                dac_l_valid,
    input  logic                dac_l_ready,
    output logic [SAMPLE_W-1:0] dac_r_data,
    output logic                dac_r_valid,
    input  logic                dac_r_ready,
    input  logic [GAIN_W-1:0]   gain,
    input  logic                mute,
    output logic [CLIP_W-1:0]   clip_count,
    output logic [1:0]          dbg_state
);

    // Every stream uses valid/ready: a beat transfers on a rising clk edge where
    // both are high; a producer holds data stable while valid is high and unaccepted.

    state_e              state_q, state_d;
    logic                l_cap_q, l_cap_d, r_cap_q, r_cap_d;
    logic [SAMPLE_W-1:0] l_smp_q, l_smp_d, r_smp_q, r_smp_d;
    logic                l_rdy_q, l_rdy_d, r_rdy_q, r_rdy_d;
    logic                mute_q, mute_d;
    logic [SAMPLE_W-1:0] l_out_q, l_out_d, r_out_q, r_out_d;
    logic                l_vld_q, l_vld_d, r_vld_q, r_vld_d;
    logic [CLIP_W-1:0]   clip_q, clip_d;

    logic [SAMPLE_W-1:0] l_res, r_res;
    logic                l_clip, r_clip;
    logic [1:0]          n_clip;
    logic [CLIP_W:0]     clip_sum;
    logic                load_mult;

    assign load_mult = (state_q == MULT);

    audio_gain_sat u_sat_l (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_mult),
        .sample_i (l_smp_q),
        .gain_i   (gain),
        .result_o (l_res),
        .clip_o   (l_clip)
    );

    audio_gain_sat u_sat_r (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_mult),
        .sample_i (r_smp_q),
        .gain_i   (gain),
        .result_o (r_res),
        .clip_o   (r_clip)
    );

    assign n_clip   = {1'b0, l_clip} + {1'b0, r_clip};
    assign clip_sum = {1'b0, clip_q} + {{(CLIP_W-1){1'b0}}, n_clip};

    always_comb begin
        state_d = state_q;
        l_cap_d = l_cap_q;
        r_cap_d = r_cap_q;
        l_smp_d = l_smp_q;
        r_smp_d = r_smp_q;
        mute_d  = mute_q;
        l_out_d = l_out_q;
        r_out_d = r_out_q;
        l_vld_d = l_vld_q;
        r_vld_d = r_vld_q;
        clip_d  = clip_q;
        case (state_q)
            COLLECT: begin
                if (adc_l_valid && l_rdy_q) begin
                    l_cap_d = 1'b1;
                    l_smp_d = adc_l_data;
                end
                if (adc_r_valid && r_rdy_q) begin
                    r_cap_d = 1'b1;
                    r_smp_d = adc_r_data;
                end
                if (l_cap_d && r_cap_d) begin
                    state_d = MULT;
                end
            end
            MULT: begin
                mute_d  = mute;
                state_d = SAT;
            end
            SAT: begin
                l_out_d = mute_q ? '0 : l_res;
                r_out_d = mute_q ? '0 : r_res;
                l_vld_d = 1'b1;
                r_vld_d = 1'b1;
                if (!mute_q) begin
                    clip_d = clip_sum[CLIP_W] ? {CLIP_W{1'b1}} : clip_sum[CLIP_W-1:0];
                end
                state_d = OUT;
            end
            OUT: begin
                if (dac_l_ready) begin
                    l_vld_d = 1'b0;
                end
                if (dac_r_ready) begin
                    r_vld_d = 1'b0;
                end
                if (!l_vld_d && !r_vld_d) begin
                    state_d = COLLECT;
                    l_cap_d = 1'b0;
                    r_cap_d = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
        // Registered readies keep them low through reset and rise one cycle later.
        l_rdy_d = (state_d == COLLECT) && !l_cap_d;
        r_rdy_d = (state_d == COLLECT) && !r_cap_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            l_cap_q <= 1'b0;
            r_cap_q <= 1'b0;
            l_smp_q <= '0;
            r_smp_q <= '0;
            l_rdy_q <= 1'b0;
            r_rdy_q <= 1'b0;
            mute_q  <= 1'b0;
            l_out_q <= '0;
            r_out_q <= '0;
            l_vld_q <= 1'b0;
            r_vld_q <= 1'b0;
            clip_q  <= '0;
        end else begin
            state_q <= state_d;
            l_cap_q <= l_cap_d;
            r_cap_q <= r_cap_d;
            l_smp_q <= l_smp_d;
            r_smp_q <= r_smp_d;
            l_rdy_q <= l_rdy_d;
            r_rdy_q <= r_rdy_d;
            mute_q  <= mute_d;
            l_out_q <= l_out_d;
            r_out_q <= r_out_d;
            l_vld_q <= l_vld_d;
            r_vld_q <= r_vld_d;
            clip_q  <= clip_d;
        end
    end

    assign adc_l_ready = l_rdy_q;
    assign adc_r_ready = r_rdy_q;
    assign dac_l_data  = l_out_q;
    assign dac_r_data  = r_out_q;
    assign dac_l_valid = l_vld_q;
    assign dac_r_valid = r_vld_q;
    assign clip_count  = clip_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_audio_stereo_gain.sv
// Directed bench for audio_stereo_gain: table of gain/saturation vectors plus
// hand-written handshake, latency, reset and clip-counter corner sequences.
module tb_audio_stereo_gain;
    import audio_fx_pkg::*;

    localparam int CW = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [SAMPLE_W-1:0] adc_l_data = '0, adc_r_data = '0;
    logic                adc_l_valid = 1'b0, adc_r_valid = 1'b0;
    logic                adc_l_ready, adc_r_ready;
    logic [SAMPLE_W-1:0] dac_l_data, dac_r_data;
    logic                dac_l_valid, dac_r_valid;
    logic                dac_l_ready = 1'b0, dac_r_ready = 1'b0;
    logic [GAIN_W-1:0]   gain = GAIN_UNITY;
    logic                mute = 1'b0;
    logic [CW-1:0]       clip_count;
    logic [1:0]          dbg_state;

    audio_stereo_gain #(.CLIP_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .adc_l_data  (adc_l_data),
        .adc_l_valid (adc_l_valid),
        .adc_l_ready (adc_l_ready),
        .adc_r_data  (adc_r_data),
        .adc_r_valid (adc_r_valid),
        .adc_r_ready (adc_r_ready),
        .dac_l_data  (dac_l_data),
        .dac_l_valid (dac_l_valid),
        .dac_l_ready (dac_l_ready),
        .dac_r_data  (dac_r_data),
        .dac_r_valid (dac_r_valid),
        .dac_r_ready (dac_r_ready),
        .gain        (gain),
        .mute        (mute),
        .clip_count  (clip_count),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] gain;
        logic        mute;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] el;
        logic [23:0] er;
        int          ncl;
    } vec_t;

    vec_t          vecs[10];
    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] exp_clip = '0;
    logic [47:0]   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input int n);
        int s;
        s = int'(a) + n;
        return (s > (1 << CW) - 1) ? {CW{1'b1}} : CW'(s);
    endfunction

    // Starts at posedge+1; returns at posedge+1 after both samples were taken.
    task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
        bit l_done, r_done, lf, rf;
        l_done = 0;
        r_done = 0;
        adc_l_data  = l;
        adc_r_data  = r;
        adc_l_valid = 1'b1;
        adc_r_valid = 1'b1;
        for (int c = 0; c < 20 && !(l_done && r_done); c++) begin
            @(negedge clk);
            lf = adc_l_valid && adc_l_ready;
            rf = adc_r_valid && adc_r_ready;
            @(posedge clk);
            #1;
            if (lf) begin adc_l_valid = 1'b0; l_done = 1; end
            if (rf) begin adc_r_valid = 1'b0; r_done = 1; end
        end
        if (!(l_done && r_done)) begin
            check("capture_timeout", 32'd0, 32'd1);
            adc_l_valid = 1'b0;
            adc_r_valid = 1'b0;
        end
    endtask

    // Returns at a negedge where both DAC valids are high, or flags a timeout.
    task automatic wait_out(output bit ok);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dac_l_valid && dac_r_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("output_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept_both();
        dac_l_ready = 1'b1;
        dac_r_ready = 1'b1;
        @(posedge clk);
        #1;
        dac_l_ready = 1'b0;
        dac_r_ready = 1'b0;
        @(negedge clk);
        check("valids_cleared", {30'd0, dac_l_valid, dac_r_valid}, 32'd0);
        check("clip_count", 32'(clip_count), 32'(exp_clip));
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input vec_t v, input string name);
        bit          ok;
        logic [47:0] e;
        gain = v.gain;
        mute = v.mute;
        exp_q.push_back({v.el, v.er});
        if (!v.mute) exp_clip = sat_add(exp_clip, v.ncl);
        push_pair(v.l, v.r);
        wait_out(ok);
        e = exp_q.pop_front();
        if (ok) begin
            check({name, "_l"}, 32'(dac_l_data), 32'(e[47:24]));
            check({name, "_r"}, 32'(dac_r_data), 32'(e[23:0]));
        end
        accept_both();
    endtask

    vec_t clip2, clip1;
    bit   ok;
    int   l_hi, early, extra, r_hi, l_bad, rdy_hi, guard;

    initial begin
        vecs[0] = '{16'h4000, 1'b0, 24'h123456, 24'hEDCBAA, 24'h123456, 24'hEDCBAA, 0};
        vecs[1] = '{16'h8000, 1'b0, 24'h500000, 24'hA00000, 24'h7FFFFF, 24'h800000, 2};
        vecs[2] = '{16'h2000, 1'b0, 24'h000003, 24'hFFFFFD, 24'h000002, 24'hFFFFFF, 0};
        vecs[3] = '{16'h2000, 1'b1, 24'h400000, 24'h000123, 24'h000000, 24'h000000, 0};
        vecs[4] = '{16'h8000, 1'b1, 24'h500000, 24'hA00000, 24'h000000, 24'h000000, 2};
        vecs[5] = '{16'h0000, 1'b0, 24'h7FFFFF, 24'h800000, 24'h000000, 24'h000000, 0};
        vecs[6] = '{16'h6000, 1'b0, 24'h000003, 24'hFFFFFD, 24'h000005, 24'hFFFFFC, 0};
        vecs[7] = '{16'hFFFF, 1'b0, 24'h200000, 24'hE00000, 24'h7FFF80, 24'h800080, 0};
        vecs[8] = '{16'h4000, 1'b0, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 0};
        vecs[9] = '{16'h4001, 1'b0, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 2};
        clip2   = vecs[1];
        clip1   = '{16'h4001, 1'b0, 24'h7FFFFF, 24'h000000, 24'h7FFFFF, 24'h000000, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_adc_ready", {30'd0, adc_l_ready, adc_r_ready}, 32'd0);
        check("rst_dac_valid", {30'd0, dac_l_valid, dac_r_valid}, 32'd0);
        check("rst_dac_l_data", 32'(dac_l_data), 32'd0);
        check("rst_dac_r_data", 32'(dac_r_data), 32'd0);
        check("rst_clip", 32'(clip_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(COLLECT));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first_ready", {30'd0, adc_l_ready, adc_r_ready}, 32'd3);
        @(posedge clk);
        #1;

        // Gain, rounding, saturation and mute vectors
        for (int i = 0; i < 10; i++) begin
            do_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // L and R five cycles apart: one frame, valids at cycle 8
        gain  = GAIN_UNITY;
        mute  = 1'b0;
        l_hi  = 0;
        early = 0;
        for (int c = 0; c <= 8; c++) begin
            adc_l_valid = (c == 0);
            adc_l_data  = 24'h0ABCDE;
            adc_r_valid = (c == 5);
            adc_r_data  = 24'hF00001;
            @(negedge clk);
            if (c == 0) check("t4_l_ready_c0", 32'(adc_l_ready), 32'd1);
            if (c == 5) check("t4_r_ready_c5", 32'(adc_r_ready), 32'd1);
            if (c >= 1 && c <= 7) begin
                if (adc_l_ready) l_hi++;
                if (dac_l_valid || dac_r_valid) early++;
            end
            if (c == 8) begin
                check("t4_valids_c8", {30'd0, dac_l_valid, dac_r_valid}, 32'd3);
                check("t4_l_data", 32'(dac_l_data), 32'h0ABCDE);
                check("t4_r_data", 32'(dac_r_data), 32'hF00001);
            end
            if (c < 8) begin
                @(posedge clk);
                #1;
            end
        end
        adc_l_valid = 1'b0;
        adc_r_valid = 1'b0;
        check("t4_l_ready_low", 32'(l_hi), 32'd0);
        check("t4_no_early_valid", 32'(early), 32'd0);
        accept_both();
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (dac_l_valid || dac_r_valid) extra++;
        end
        check("t4_single_frame", 32'(extra), 32'd0);
        @(posedge clk);
        #1;

        // R accepted at once, L held back for ten cycles
        push_pair(24'h111111, 24'h222222);
        wait_out(ok);
        dac_r_ready = 1'b1;
        dac_l_ready = 1'b0;
        r_hi   = 0;
        l_bad  = 0;
        rdy_hi = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (dac_r_valid) r_hi++;
            if (!dac_l_valid || dac_l_data !== 24'h111111) l_bad++;
            if (adc_l_ready || adc_r_ready) rdy_hi++;
        end
        check("t5_r_valid_dropped", 32'(r_hi), 32'd0);
        check("t5_l_held", 32'(l_bad), 32'd0);
        check("t5_adc_ready_low", 32'(rdy_hi), 32'd0);
        dac_r_ready = 1'b0;
        dac_l_ready = 1'b1;
        @(posedge clk);
        #1;
        dac_l_ready = 1'b0;
        @(negedge clk);
        check("t5_l_valid_cleared", 32'(dac_l_valid), 32'd0);
        check("t5_ready_back", {30'd0, adc_l_ready, adc_r_ready}, 32'd3);
        @(posedge clk);
        #1;

        // Reset during OUT drops the frame
        push_pair(24'h333333, 24'h444444);
        wait_out(ok);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valids_zero", {30'd0, dac_l_valid, dac_r_valid}, 32'd0);
        check("t6_readies_zero", {30'd0, adc_l_ready, adc_r_ready}, 32'd0);
        check("t6_clip_zero", 32'(clip_count), 32'd0);
        exp_clip = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_ready_after_release", {30'd0, adc_l_ready, adc_r_ready}, 32'd3);
        check("t6_no_stale_valid", {30'd0, dac_l_valid, dac_r_valid}, 32'd0);
        @(posedge clk);
        #1;
        do_frame('{16'h4000, 1'b0, 24'h055555, 24'hFAAAAA, 24'h055555, 24'hFAAAAA, 0}, "t6_next");

        // Clip counter saturation
        guard = 0;
        while (exp_clip < CW'(8'hFE) && guard < 200) begin
            do_frame((exp_clip == CW'(8'hFD)) ? clip1 : clip2, "t7_fill");
            guard++;
        end
        check("t7_near_max", 32'(clip_count), 32'h0FE);
        do_frame(clip2, "t7_hit");
        check("t7_saturated", 32'(clip_count), 32'h0FF);
        do_frame(clip2, "t7_hold");
        check("t7_holds", 32'(clip_count), 32'h0FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
